pipe_stage_buffer: RTL and testbench
====================================

Name: pipe_stage_buffer

Overview:
- Parametrised, elastic pipeline stage register carrying PC (or any payload) between two stages.
- Generalises the fixed 32-bit pass-through stage buffer with:
  - valid/ready handshake on both sides;
  - a 2-entry skid buffer, so upstream ready is fully registered;
  - synchronous flush for branch/jump squash;
  - configurable width and bubble value.
- Instanced between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 32, payload width in bits.
- RST_VAL, '0 (DATA_W bits), value driven on out_data after reset or flush (the bubble value).
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  payload available to downstream.
- out_ready  input  1  downstream accepts; low means stall.
- out_data  output  DATA_W  payload to downstream; registered.
- stall_cnt  output  CNT_W  present only under PIPE_STAGE_PERF_EN.
- bubble_cnt  output  CNT_W  present only under PIPE_STAGE_PERF_EN.

Behaviour:
- Definitions: in fire = in_valid & in_ready; out fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- State encoding: EMPTY, BUSY, FULL.
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), driven from a flop.
- Reset (rst=0, asynchronous): state EMPTY, out_valid 0, in_ready 1, out_data RST_VAL, skid RST_VAL, counters 0.
- Latency: 1 cycle from in fire to out_valid when the stage is empty.
- EMPTY:
  - in fire -> BUSY, main <= in_data.
- BUSY:
  - in fire & out fire -> BUSY, main <= in_data.
  - in fire & !out fire -> FULL, skid <= in_data, main holds.
  - !in fire & out fire -> EMPTY.
  - Neither -> hold.
- FULL:
  - in_ready 0, so in_valid is ignored.
  - out fire -> BUSY, main <= skid.
  - Else hold.
- Ordering: strict FIFO; no payload dropped or duplicated except on flush.
- Stall stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change (the checker asserts this).
- Flush (highest priority, overrides any same-cycle fire):
  - Next cycle: state EMPTY, out_valid 0, out_data RST_VAL, in_ready 1.
  - An in_data presented in the flush cycle is discarded.
- Reset asserted mid-transfer: immediate return to reset values; no payload survives.
- in_valid during FULL: no effect; upstream must hold per protocol.
- Throughput: 1 payload/cycle sustained when out_ready stays high.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments every cycle with out_valid=1 & out_ready=0.
  - bubble_cnt increments every cycle with out_valid=0.
  - Both saturate at 2^CNT_W-1, are cleared by reset only, and are unaffected by flush.
- Undefined: counter ports and logic absent; datapath behaviour identical.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_t.
  - localparam PIPE_PC_W = 32.
- Sub-module pipe_sat_cnt (parametrised CNT_W, inc, saturating), instanced twice under PIPE_STAGE_PERF_EN.
- Datapath and FSM stay in one module.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> out_valid=0, in_ready=1, out_data=0x0000_0000 (RST_VAL default).
- Streaming: out_ready=1, push 0x100, 0x104, 0x108 on consecutive cycles -> each appears on out_data exactly 1 cycle later, in_ready stays 1.
- Stall/skid:
  - Push 0x200 and 0x204, with out_ready=0 from the 0x204 cycle -> state FULL, in_ready=0, out_data held at 0x200.
  - Raise out_ready -> 0x200 then 0x204 delivered, no loss.
- Flush while FULL (payloads 0x300, 0x304, in_data=0x308 in flush cycle) -> next cycle out_valid=0, out_data=RST_VAL, in_ready=1, 0x308 never delivered.
- Async reset mid-stall: drop rst while out_valid=1 -> outputs reach reset values before the next clk edge.
- PIPE_STAGE_PERF_EN, CNT_W=4: stall 20 cycles -> stall_cnt saturates at 15; flush leaves it at 15; reset clears it to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: skid-buffer state encoding and PC width.
// Imported by every stage buffer and its helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_BUSY,
    PS_FULL
  } pipe_state_t;

  localparam int PIPE_PC_W = 32;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter, cleared only by asynchronous active-low reset.
// Used for stage stall/bubble statistics.
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline stage register with 2-entry skid buffer and flush.
// Optional stall/bubble counters enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = PIPE_PC_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  pipe_state_t       r_state;
  pipe_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              r_in_ready;
  logic              w_in_ready_nxt;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_out_valid = (r_state != PS_EMPTY);
  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= PS_EMPTY;
      r_main     <= RST_VAL;
      r_skid     <= RST_VAL;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= w_in_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      PS_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = PS_BUSY;
          w_main_nxt  = in_data;
        end
      end
      PS_BUSY: begin
        unique case (1'b1)
          (w_in_fire && w_out_fire): begin
            w_main_nxt = in_data;
          end
          (w_in_fire && !w_out_fire): begin
            w_state_nxt = PS_FULL;
            w_skid_nxt  = in_data;
          end
          (!w_in_fire && w_out_fire): begin
            w_state_nxt = PS_EMPTY;
          end
          default: ;
        endcase
      end
      PS_FULL: begin
        if (w_out_fire) begin
          w_state_nxt = PS_BUSY;
          w_main_nxt  = r_skid;
        end
      end
      default: begin
        w_state_nxt = PS_EMPTY;
      end
    endcase
    // Squash wins over any same-cycle transfer.
    if (flush) begin
      w_state_nxt = PS_EMPTY;
      w_main_nxt  = RST_VAL;
      w_skid_nxt  = RST_VAL;
    end
    w_in_ready_nxt = (w_state_nxt != PS_FULL);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main;

`ifdef PIPE_STAGE_PERF_EN
  logic w_stall;
  logic w_bubble;

  assign w_stall  = w_out_valid & ~out_ready;
  assign w_bubble = ~w_out_valid;

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_bubble),
    .cnt (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed self-checking bench for pipe_stage_buffer.
// Counter checks are active when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]  stall_cnt;
  logic [3:0]  bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer #(
    .DATA_W  (32),
    .RST_VAL (32'h0),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  // Stall stability: a held payload may not move or vanish.
  logic        p_stall = 1'b0;
  logic [31:0] p_data = '0;
  bit          rst_hit = 1'b0;

  always @(negedge rst) rst_hit = 1'b1;

  always @(posedge clk) begin
    if (p_stall && rst && !rst_hit) begin
      chk("stall_valid", {31'b0, out_valid}, 32'h1);
      chk("stall_data", out_data, p_data);
    end
    p_stall = out_valid & ~out_ready & ~flush & rst;
    p_data  = out_data;
    rst_hit = 1'b0;
  end

  initial begin
    // Reset held for three cycles
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_data", out_data, 32'h0);

    // Streaming
    in_valid  = 1'b1;
    in_data   = 32'h100;
    out_ready = 1'b1;
    @(negedge clk);
    chk("s0_valid", {31'b0, out_valid}, 32'h1);
    chk("s0_data", out_data, 32'h100);
    chk("s0_ready", {31'b0, in_ready}, 32'h1);
    in_data = 32'h104;
    @(negedge clk);
    chk("s1_data", out_data, 32'h104);
    chk("s1_ready", {31'b0, in_ready}, 32'h1);
    in_data = 32'h108;
    @(negedge clk);
    chk("s2_data", out_data, 32'h108);
    chk("s2_ready", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("s3_empty", {31'b0, out_valid}, 32'h0);

    // Stall and skid
    in_valid = 1'b1;
    in_data  = 32'h200;
    @(negedge clk);
    chk("k0_data", out_data, 32'h200);
    in_data   = 32'h204;
    out_ready = 1'b0;
    @(negedge clk);
    chk("k1_ready", {31'b0, in_ready}, 32'h0);
    chk("k1_data", out_data, 32'h200);
    chk("k1_valid", {31'b0, out_valid}, 32'h1);
    in_data = 32'h2ff;
    @(negedge clk);
    chk("k2_ready", {31'b0, in_ready}, 32'h0);
    chk("k2_data", out_data, 32'h200);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("k3_data", out_data, 32'h204);
    chk("k3_valid", {31'b0, out_valid}, 32'h1);
    chk("k3_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    chk("k4_empty", {31'b0, out_valid}, 32'h0);

    // Flush while full
    in_valid  = 1'b1;
    in_data   = 32'h300;
    out_ready = 1'b0;
    @(negedge clk);
    in_data = 32'h304;
    @(negedge clk);
    chk("f0_ready", {31'b0, in_ready}, 32'h0);
    chk("f0_data", out_data, 32'h300);
    flush     = 1'b1;
    in_data   = 32'h308;
    out_ready = 1'b1;
    @(negedge clk);
    chk("f1_valid", {31'b0, out_valid}, 32'h0);
    chk("f1_data", out_data, 32'h0);
    chk("f1_ready", {31'b0, in_ready}, 32'h1);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("f2_valid", {31'b0, out_valid}, 32'h0);
    chk("f2_data", out_data, 32'h0);

    // Async reset during a stall
    in_valid  = 1'b1;
    in_data   = 32'h400;
    out_ready = 1'b0;
    @(negedge clk);
    chk("a0_data", out_data, 32'h400);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("a1_valid", {31'b0, out_valid}, 32'h0);
    chk("a1_data", out_data, 32'h0);
    chk("a1_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    #1 rst = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h500;
    @(negedge clk);
    in_valid = 1'b0;
    chk("p_bubble", {28'b0, bubble_cnt}, 32'h2);
    repeat (20) @(negedge clk);
    chk("p_stall_sat", {28'b0, stall_cnt}, 32'hf);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("p_stall_flush", {28'b0, stall_cnt}, 32'hf);
    rst = 1'b0;
    #1;
    chk("p_stall_rst", {28'b0, stall_cnt}, 32'h0);
    chk("p_bubble_rst", {28'b0, bubble_cnt}, 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
`endif

    @(negedge clk);
    chk("end_empty", {31'b0, out_valid}, 32'h0);
    chk("end_ready", {31'b0, in_ready}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
